// File: rtl/rtc_calendar.sv
// Real-time clock/calendar: prescaled one-second tick, hh:mm:ss and dd.mm.yyyy with
// Gregorian leap years, time/date overwrites, and ALARM_N hh:mm alarms with sticky flags.
`timescale 1ns/1ps
module rtc_calendar #(
  parameter int CLK_PER_SEC = 100_000_000,
  parameter int YEAR_W      = 12,
  parameter int YEAR_RST    = 2020,
  parameter int ALARM_N     = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [16:0]           time_in,
  input  logic                  time_ow,
  input  logic [9+YEAR_W-1:0]   date_in,
  input  logic                  date_ow,
  input  logic [11*ALARM_N-1:0] alarm_time,
  input  logic [ALARM_N-1:0]    alarm_en,
  input  logic [ALARM_N-1:0]    alarm_ack,
  output logic [16:0]           time_out,
  output logic [9+YEAR_W-1:0]   date_out,
  output logic                  sec_tick,
  output logic                  day_tick,
  output logic [ALARM_N-1:0]    alarm_pulse,
  output logic [ALARM_N-1:0]    alarm_flag
);

  localparam int PW = (CLK_PER_SEC > 1) ? $clog2(CLK_PER_SEC) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_PER_SEC - 1);

  logic [PW-1:0]     r_presc;
  logic [4:0]        r_hour;
  logic [5:0]        r_min;
  logic [5:0]        r_sec;
  logic [4:0]        r_day;
  logic [3:0]        r_month;
  logic [YEAR_W-1:0] r_year;
  logic              r_sec_tick;
  logic              r_day_tick;
  logic [ALARM_N-1:0] r_alarm_pulse;
  logic [ALARM_N-1:0] r_alarm_flag;

  logic              w_tick;
  logic              w_wrap;
  logic              w_day_adv;
  logic [4:0]        w_hour_nx;
  logic [5:0]        w_min_nx;
  logic [5:0]        w_sec_nx;
  logic [4:0]        w_dim;
  logic              w_leap;
  logic [31:0]       w_year32;
  logic [4:0]        w_day_nx;
  logic [3:0]        w_month_nx;
  logic [YEAR_W-1:0] w_year_nx;
  logic [ALARM_N-1:0] w_match;

  // An overwrite in the tick cycle swallows that tick entirely.
  assign w_tick    = (r_presc == PRESC_MAX) && !time_ow;
  assign w_day_adv = w_tick && w_wrap;

  always_comb begin
    w_sec_nx  = r_sec + 6'd1;
    w_min_nx  = r_min;
    w_hour_nx = r_hour;
    w_wrap    = 1'b0;
    if (r_sec >= 6'd59) begin
      w_sec_nx = 6'd0;
      w_min_nx = r_min + 6'd1;
      if (r_min >= 6'd59) begin
        w_min_nx  = 6'd0;
        w_hour_nx = r_hour + 5'd1;
        if (r_hour >= 5'd23) begin
          w_hour_nx = 5'd0;
          w_wrap    = 1'b1;
        end
      end
    end
  end

  assign w_year32 = 32'(r_year);
  assign w_leap   = (w_year32 % 32'd4 == 32'd0) &&
                    ((w_year32 % 32'd100 != 32'd0) || (w_year32 % 32'd400 == 32'd0));

  always_comb begin
    case (r_month)
      4'd4, 4'd6, 4'd9, 4'd11: w_dim = 5'd30;
      4'd2:                    w_dim = w_leap ? 5'd29 : 5'd28;
      default:                 w_dim = 5'd31;
    endcase
  end

  always_comb begin
    w_day_nx   = r_day + 5'd1;
    w_month_nx = r_month;
    w_year_nx  = r_year;
    if (r_day >= w_dim) begin
      w_day_nx = 5'd1;
      if (r_month >= 4'd12) begin
        w_month_nx = 4'd1;
        w_year_nx  = r_year + 1'b1;
      end else begin
        w_month_nx = r_month + 4'd1;
      end
    end
  end

  generate
    for (genvar gi = 0; gi < ALARM_N; gi++) begin : g_alarm
      assign w_match[gi] = w_tick && (w_sec_nx == 6'd0) && alarm_en[gi] &&
                           ({w_hour_nx, w_min_nx} == alarm_time[11*gi +: 11]);
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_presc       <= '0;
      r_hour        <= '0;
      r_min         <= '0;
      r_sec         <= '0;
      r_day         <= 5'd1;
      r_month       <= 4'd1;
      r_year        <= YEAR_W'(YEAR_RST);
      r_sec_tick    <= 1'b0;
      r_day_tick    <= 1'b0;
      r_alarm_pulse <= '0;
      r_alarm_flag  <= '0;
    end else begin
      r_sec_tick    <= w_tick;
      r_day_tick    <= w_day_adv;
      r_alarm_pulse <= w_match;
      // Set beats a simultaneous acknowledge.
      r_alarm_flag  <= (r_alarm_flag & ~alarm_ack) | w_match;

      if (time_ow) begin
        r_presc                 <= '0;
        {r_hour, r_min, r_sec}  <= time_in;
      end else if (w_tick) begin
        r_presc <= '0;
        r_hour  <= w_hour_nx;
        r_min   <= w_min_nx;
        r_sec   <= w_sec_nx;
      end else begin
        r_presc <= r_presc + 1'b1;
      end

      if (date_ow) begin
        {r_day, r_month, r_year} <= date_in;
      end else if (w_day_adv) begin
        r_day   <= w_day_nx;
        r_month <= w_month_nx;
        r_year  <= w_year_nx;
      end
    end
  end

  assign time_out    = {r_hour, r_min, r_sec};
  assign date_out    = {r_day, r_month, r_year};
  assign sec_tick    = r_sec_tick;
  assign day_tick    = r_day_tick;
  assign alarm_pulse = r_alarm_pulse;
  assign alarm_flag  = r_alarm_flag;

endmodule

// File: tb/tb_rtc_calendar.sv
// Directed bench for rtc_calendar with a 4-cycle second: rollover, leap years,
// overwrite priority, alarms, asynchronous reset and out-of-range field values.
`timescale 1ns/1ps
module tb_rtc_calendar;

  localparam int CPS = 4;
  localparam int YW  = 12;
  localparam int AN  = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [16:0]     time_in;
  logic            time_ow;
  logic [9+YW-1:0] date_in;
  logic            date_ow;
  logic [11*AN-1:0] alarm_time;
  logic [AN-1:0]   alarm_en;
  logic [AN-1:0]   alarm_ack;
  logic [16:0]     time_out;
  logic [9+YW-1:0] date_out;
  logic            sec_tick;
  logic            day_tick;
  logic [AN-1:0]   alarm_pulse;
  logic [AN-1:0]   alarm_flag;

  int n_vec = 0;
  int n_err = 0;

  rtc_calendar #(.CLK_PER_SEC(CPS), .YEAR_W(YW), .YEAR_RST(2020), .ALARM_N(AN)) dut (
    .clk(clk), .rst(rst),
    .time_in(time_in), .time_ow(time_ow),
    .date_in(date_in), .date_ow(date_ow),
    .alarm_time(alarm_time), .alarm_en(alarm_en), .alarm_ack(alarm_ack),
    .time_out(time_out), .date_out(date_out),
    .sec_tick(sec_tick), .day_tick(day_tick),
    .alarm_pulse(alarm_pulse), .alarm_flag(alarm_flag)
  );

  always #5 clk = ~clk;

  function automatic logic [16:0] tp(input int h, input int m, input int s);
    return {5'(h), 6'(m), 6'(s)};
  endfunction

  function automatic logic [20:0] dp(input int d, input int mo, input int y);
    return {5'(d), 4'(mo), 12'(y)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [16:0] t, input logic [20:0] d, input logic wt, input logic wd);
    time_in = t;
    date_in = d;
    time_ow = wt;
    date_ow = wd;
    step(1);
    time_ow = 1'b0;
    date_ow = 1'b0;
  endtask

  initial begin
    rst        = 1'b1;
    time_in    = '0;
    time_ow    = 1'b0;
    date_in    = '0;
    date_ow    = 1'b0;
    alarm_time = {11'({5'd6, 6'd30}), 11'({5'd6, 6'd30})};
    alarm_en   = '0;
    alarm_ack  = '0;

    step(1);
    chk("rst_time", 32'(time_out), 32'(tp(0, 0, 0)));
    chk("rst_date", 32'(date_out), 32'(dp(1, 1, 2020)));
    chk("rst_sec_tick", 32'(sec_tick), 32'd0);
    chk("rst_day_tick", 32'(day_tick), 32'd0);
    chk("rst_flag", 32'(alarm_flag), 32'd0);
    chk("rst_pulse", 32'(alarm_pulse), 32'd0);
    rst = 1'b0;
    $display("step reset released");

    // Rollover into a leap day
    load(tp(23, 59, 58), dp(28, 2, 2020), 1'b1, 1'b1);
    chk("ow_time", 32'(time_out), 32'(tp(23, 59, 58)));
    chk("ow_date", 32'(date_out), 32'(dp(28, 2, 2020)));
    step(3);
    chk("pre_tick", 32'(sec_tick), 32'd0);
    step(1);
    chk("t59_time", 32'(time_out), 32'(tp(23, 59, 59)));
    chk("t59_sec_tick", 32'(sec_tick), 32'd1);
    chk("t59_day_tick", 32'(day_tick), 32'd0);
    step(3);
    chk("gap_sec_tick", 32'(sec_tick), 32'd0);
    step(1);
    chk("mid_time", 32'(time_out), 32'(tp(0, 0, 0)));
    chk("mid_day_tick", 32'(day_tick), 32'd1);
    chk("mid_date", 32'(date_out), 32'(dp(29, 2, 2020)));
    step(1);
    chk("mid_day_tick_off", 32'(day_tick), 32'd0);
    $display("step rollover 28.02.2020 done");

    load(tp(23, 59, 59), dp(28, 2, 2100), 1'b1, 1'b1);
    step(4);
    chk("leap_2100", 32'(date_out), 32'(dp(1, 3, 2100)));
    load(tp(23, 59, 59), dp(28, 2, 2000), 1'b1, 1'b1);
    step(4);
    chk("leap_2000", 32'(date_out), 32'(dp(29, 2, 2000)));
    load(tp(23, 59, 59), dp(31, 12, 4095), 1'b1, 1'b1);
    step(4);
    chk("year_wrap", 32'(date_out), 32'(dp(1, 1, 0)));
    $display("step leap years done");

    // date_ow coincides with the midnight tick
    load(tp(23, 59, 59), dp(31, 1, 2020), 1'b1, 1'b1);
    step(3);
    date_in = dp(15, 1, 2020);
    date_ow = 1'b1;
    step(1);
    date_ow = 1'b0;
    chk("dow_date", 32'(date_out), 32'(dp(15, 1, 2020)));
    chk("dow_day_tick", 32'(day_tick), 32'd1);
    chk("dow_time", 32'(time_out), 32'(tp(0, 0, 0)));
    // time_ow coincides with a tick
    step(3);
    time_in = tp(12, 34, 56);
    time_ow = 1'b1;
    step(1);
    time_ow = 1'b0;
    chk("tow_time", 32'(time_out), 32'(tp(12, 34, 56)));
    chk("tow_sec_tick", 32'(sec_tick), 32'd0);
    step(3);
    chk("tow_wait_tick", 32'(sec_tick), 32'd0);
    step(1);
    chk("tow_next_time", 32'(time_out), 32'(tp(12, 34, 57)));
    chk("tow_next_tick", 32'(sec_tick), 32'd1);
    $display("step overwrite priority done");

    // Alarms: channel 0 enabled, channel 1 disabled, both at 06:30
    alarm_en = 2'b01;
    load(tp(6, 29, 59), dp(1, 1, 2020), 1'b1, 1'b0);
    step(4);
    chk("al_time", 32'(time_out), 32'(tp(6, 30, 0)));
    chk("al_pulse", 32'(alarm_pulse), 32'b01);
    chk("al_flag", 32'(alarm_flag), 32'b01);
    step(1);
    chk("al_pulse_off", 32'(alarm_pulse), 32'b00);
    chk("al_flag_sticky", 32'(alarm_flag), 32'b01);
    alarm_ack = 2'b01;
    step(1);
    alarm_ack = 2'b00;
    chk("al_ack", 32'(alarm_flag), 32'b00);
    load(tp(6, 29, 59), dp(1, 1, 2020), 1'b1, 1'b0);
    step(3);
    alarm_ack = 2'b01;
    step(1);
    alarm_ack = 2'b00;
    chk("al_set_wins", 32'(alarm_flag), 32'b01);
    chk("al_pulse2", 32'(alarm_pulse), 32'b01);
    alarm_en = 2'b00;
    step(1);
    chk("al_en_off_keeps", 32'(alarm_flag), 32'b01);
    alarm_ack = 2'b01;
    step(1);
    alarm_ack = 2'b00;
    chk("al_ack2", 32'(alarm_flag), 32'b00);
    alarm_en = 2'b01;
    load(tp(6, 30, 0), dp(1, 1, 2020), 1'b1, 1'b0);
    chk("al_ow_pulse", 32'(alarm_pulse), 32'b00);
    chk("al_ow_flag", 32'(alarm_flag), 32'b00);
    step(4);
    chk("al_nomatch_time", 32'(time_out), 32'(tp(6, 30, 1)));
    chk("al_nomatch_pulse", 32'(alarm_pulse), 32'b00);
    $display("step alarms done");

    // Asynchronous reset between edges
    load(tp(10, 20, 30), dp(5, 6, 2021), 1'b1, 1'b1);
    step(2);
    #2 rst = 1'b1;
    #1;
    chk("arst_time", 32'(time_out), 32'(tp(0, 0, 0)));
    chk("arst_date", 32'(date_out), 32'(dp(1, 1, 2020)));
    #1 rst = 1'b0;
    step(3);
    chk("arst_no_tick", 32'(sec_tick), 32'd0);
    step(1);
    chk("arst_tick", 32'(sec_tick), 32'd1);
    chk("arst_time1", 32'(time_out), 32'(tp(0, 0, 1)));
    $display("step async reset done");

    // Out-of-range fields
    load(tp(10, 5, 62), dp(31, 0, 2020), 1'b1, 1'b1);
    step(4);
    chk("ill_sec_carry", 32'(time_out), 32'(tp(10, 6, 0)));
    chk("ill_date_hold", 32'(date_out), 32'(dp(31, 0, 2020)));
    load(tp(23, 59, 62), dp(31, 0, 2020), 1'b1, 1'b0);
    step(4);
    chk("ill_mid_time", 32'(time_out), 32'(tp(0, 0, 0)));
    chk("ill_mid_day_tick", 32'(day_tick), 32'd1);
    chk("ill_mid_date", 32'(date_out), 32'(dp(1, 1, 2020)));
    $display("step illegal values done");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
